// File: rtl/regfile_sb.sv
// Parametrised register file with optional write-through bypass, a hardwired-zero
// register and a per-register busy scoreboard used by the decode-stage hazard logic.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_wr,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            issue_vld,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy1,
    output logic            busy2
);

    localparam int DEPTH = 1 << AW;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [DEPTH-1:0] addr_ok;
    logic             wr_ok;
    logic             set_ok;
    logic             byp1;
    logic             byp2;

    // addr_ok marks every address that names real, writable state: in range and
    // not the hardwired zero register. Built per address so no runtime compare
    // against NREGS is needed when the address space is not a power of two.
    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_ok
            assign addr_ok[g] = (g < NREGS) && !(ZERO_REG && (g == 0));
        end
    endgenerate

    assign wr_ok  = reg_wr & addr_ok[waddr];
    assign set_ok = issue_vld & addr_ok[issue_rd];
    assign byp1   = BYPASS & reg_wr & (waddr == raddr1);
    assign byp2   = BYPASS & reg_wr & (waddr == raddr2);

    always_comb begin
        rdata1 = '0;
        if (addr_ok[raddr1]) begin
            if (byp1) rdata1 = wdata;
            else      rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (addr_ok[raddr2]) begin
            if (byp2) rdata2 = wdata;
            else      rdata2 = regs[raddr2];
        end
    end

    assign busy1 = addr_ok[raddr1] & busy[raddr1] & ~byp1;
    assign busy2 = addr_ok[raddr2] & busy[raddr2] & ~byp2;

    // Set is applied after clear: a newly issued producer outranks the one retiring.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)  busy_nxt[waddr]    = 1'b0;
        if (set_ok) busy_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) regs[waddr] <= wdata;
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default 32x32 instance and a 24x64 instance,
// driven with directed vectors; a negedge monitor checks queued expectations.
module tb_regfile_sb;

    logic clk;
    logic rst;

    // default instance (XLEN=32, NREGS=32)
    logic        reg_wr, issue_vld;
    logic [4:0]  waddr, raddr1, raddr2, issue_rd;
    logic [31:0] wdata, rdata1, rdata2;
    logic        busy1, busy2;

    // parametric instance (XLEN=64, NREGS=24)
    logic        p_reg_wr, p_issue_vld;
    logic [4:0]  p_waddr, p_raddr1, p_raddr2, p_issue_rd;
    logic [63:0] p_wdata, p_rdata1, p_rdata2;
    logic        p_busy1, p_busy2;

    regfile_sb dut (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .issue_vld(issue_vld), .issue_rd(issue_rd), .busy1(busy1), .busy2(busy2)
    );

    regfile_sb #(.XLEN(64), .NREGS(24)) dut_p (
        .clk(clk), .rst(rst), .reg_wr(p_reg_wr), .waddr(p_waddr), .wdata(p_wdata),
        .raddr1(p_raddr1), .raddr2(p_raddr2), .rdata1(p_rdata1), .rdata2(p_rdata2),
        .issue_vld(p_issue_vld), .issue_rd(p_issue_rd), .busy1(p_busy1), .busy2(p_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sel;
        logic [63:0] r1;
        logic [63:0] r2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [63:0] PAT = 64'hA5A5_5A5A_F00F_0FF0;

    task automatic expect_out(input string name, input bit sel,
                              input logic [63:0] r1, input logic [63:0] r2,
                              input logic b1, input logic b2);
        exp_t e;
        e.name = name; e.sel = sel; e.r1 = r1; e.r2 = r2; e.b1 = b1; e.b2 = b2;
        q.push_back(e);
    endtask

    task automatic drv(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic iv, input logic [4:0] ird);
        reg_wr = wr; waddr = wa; wdata = wd; raddr1 = ra1; raddr2 = ra2;
        issue_vld = iv; issue_rd = ird;
    endtask

    task automatic pdrv(input logic wr, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic iv, input logic [4:0] ird);
        p_reg_wr = wr; p_waddr = wa; p_wdata = wd; p_raddr1 = ra1; p_raddr2 = ra2;
        p_issue_vld = iv; p_issue_rd = ird;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so every queued expectation is checked
    // at the negedge following the cycle in which it was issued.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [63:0] a1, a2;
            logic        ab1, ab2;
            e = q.pop_front();
            if (e.sel) begin
                a1 = p_rdata1; a2 = p_rdata2; ab1 = p_busy1; ab2 = p_busy2;
            end else begin
                a1 = {32'b0, rdata1}; a2 = {32'b0, rdata2}; ab1 = busy1; ab2 = busy2;
            end
            n_tests++;
            if (a1 !== e.r1 || a2 !== e.r2 || ab1 !== e.b1 || ab2 !== e.b2) begin
                n_fail++;
                $display("FAIL %s: got rdata1=%h rdata2=%h busy1=%b busy2=%b, want rdata1=%h rdata2=%h busy1=%b busy2=%b",
                         e.name, a1, a2, ab1, ab2, e.r1, e.r2, e.b1, e.b2);
            end
        end
    end

    initial begin
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        pdrv(0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        // reset then read
        rst = 1'b1;
        drv(0, 0, 0, 5, 31, 0, 0);
        pdrv(0, 0, 0, 5, 23, 0, 0);
        expect_out("reset_read", 0, 0, 0, 0, 0);
        expect_out("p_reset_read", 1, 0, 0, 0, 0);
        step();

        // write-through and persistence
        drv(1, 7, 32'hDEADBEEF, 7, 7, 0, 0);
        expect_out("bypass_wr", 0, 64'hDEADBEEF, 64'hDEADBEEF, 0, 0);
        step();
        drv(0, 7, 0, 7, 5, 0, 0);
        expect_out("wr_persist", 0, 64'hDEADBEEF, 0, 0, 0);
        step();

        // zero register ignores writes and busy-set
        drv(1, 0, 32'h1234, 0, 0, 1, 0);
        expect_out("zero_same", 0, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 7, 0, 0);
        expect_out("zero_after", 0, 0, 64'hDEADBEEF, 0, 0);
        step();
        expect_out("zero_later", 0, 0, 64'hDEADBEEF, 0, 0);
        step();

        // scoreboard lifecycle on r3
        drv(0, 0, 0, 3, 3, 1, 3);
        expect_out("issue_same", 0, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 3, 7, 0, 0);
        expect_out("busy_t1", 0, 0, 64'hDEADBEEF, 1, 0);
        step();
        expect_out("busy_t2", 0, 0, 64'hDEADBEEF, 1, 0);
        step();
        drv(1, 3, 32'h0000_0033, 3, 3, 0, 0);
        expect_out("wb_clear", 0, 64'h33, 64'h33, 0, 0);
        step();
        drv(0, 0, 0, 3, 3, 0, 0);
        expect_out("after_wb", 0, 64'h33, 64'h33, 0, 0);
        step();

        // set/clear collision on r4
        drv(0, 0, 0, 4, 7, 1, 4);
        expect_out("r4_issue", 0, 0, 64'hDEADBEEF, 0, 0);
        step();
        drv(1, 4, 32'h0000_0044, 4, 7, 1, 4);
        expect_out("collide", 0, 64'h44, 64'hDEADBEEF, 0, 0);
        step();
        drv(0, 0, 0, 4, 3, 0, 0);
        expect_out("collide_next", 0, 64'h44, 64'h33, 1, 0);
        step();
        drv(1, 9, 32'h0000_0099, 4, 9, 0, 0);
        expect_out("busy_other_wr", 0, 64'h44, 64'h99, 1, 0);
        step();

        // parametric instance: out-of-range write, 64-bit round trip
        drv(0, 0, 0, 4, 7, 0, 0);
        pdrv(1, 25, PAT, 25, 1, 0, 0);
        expect_out("p_oor_read", 1, 0, 0, 0, 0);
        step();
        pdrv(1, 23, PAT, 23, 1, 0, 0);
        expect_out("p_bypass23", 1, PAT, 0, 0, 0);
        step();
        pdrv(0, 0, 0, 23, 23, 1, 5);
        expect_out("p_rt23", 1, PAT, PAT, 0, 0);
        step();
        pdrv(0, 0, 0, 5, 25, 1, 9);
        expect_out("p_busy5", 1, 0, 0, 1, 0);
        step();
        pdrv(0, 0, 0, 5, 9, 1, 25);
        expect_out("p_busy5_9", 1, 0, 0, 1, 1);
        step();

        // reset after several issues
        rst = 1'b0;
        pdrv(0, 0, 0, 5, 23, 0, 0);
        drv(0, 0, 0, 4, 7, 0, 0);
        step();
        rst = 1'b1;
        expect_out("p_rst_clear", 1, 0, 0, 0, 0);
        expect_out("rst_clear", 0, 0, 0, 0, 0);
        step();

        // let the monitor drain, bounded
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
